// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file write-port arbiter: width defaults,
// FSM state encoding, grant encoding and a saturating counter helper.
package regfile_arb_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PEND  = 2'd1,
    S_FORCE = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_WB   = 2'd1,
    G_BUF  = 2'd2
  } arb_grant_e;

  function automatic logic [15:0] sat16_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/lu_hold_buf.sv
// One-entry holding buffer for a long-latency unit result.
// Drop and drain both empty it; the held register reads as 0 when empty.
module lu_hold_buf
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic              drop,
  input  logic              drain,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [ADDR_W-1:0] hold_reg,
  output logic [DATA_W-1:0] hold_data
);

  // Buffer entry: emptying takes precedence over loading
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid     <= 1'b0;
      hold_reg  <= '0;
      hold_data <= '0;
    end else if (drop || drain) begin
      valid     <= 1'b0;
      hold_reg  <= '0;
      hold_data <= '0;
    end else if (load) begin
      valid     <= 1'b1;
      hold_reg  <= in_reg;
      hold_data <= in_data;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between pipeline writeback
// and a buffered long-latency unit. Define ARB_STATS_EN for conflict/force counters.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_reg,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
`ifdef ARB_STATS_EN
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_forced,
`endif
  output logic              buf_busy,
  output logic [ADDR_W-1:0] buf_reg
);

  localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e        state_r, state_nxt_s;
  arb_grant_e        grant_s;
  logic [CNT_W-1:0]  starve_cnt_r, cnt_nxt_s, cnt_inc_s;
  logic              load_s, drop_s, drain_s;
  logic              buf_valid_s;
  logic [ADDR_W-1:0] buf_reg_s;
  logic [DATA_W-1:0] buf_data_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  lu_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf (
    .clock     (clock),
    .resetn    (resetn),
    .load      (load_s),
    .drop      (drop_s),
    .drain     (drain_s),
    .in_reg    (lu_reg),
    .in_data   (lu_data),
    .valid     (buf_valid_s),
    .hold_reg  (buf_reg_s),
    .hold_data (buf_data_s)
  );

  // Grant selection: a forced buffer write beats WB, otherwise WB has priority
  always_comb begin
    grant_s = G_NONE;
    case (state_r)
      S_FORCE: grant_s = G_BUF;
      S_PEND:  begin
        if (wb_valid) grant_s = G_WB;
        else          grant_s = G_BUF;
      end
      S_EMPTY: begin
        if (wb_valid) grant_s = G_WB;
        else          grant_s = G_NONE;
      end
      default: grant_s = G_NONE;
    endcase
  end

  assign wb_stall = wb_valid && (grant_s != G_WB);
  assign lu_ready = (state_r == S_EMPTY);
  assign buf_busy = buf_valid_s;
  assign buf_reg  = buf_reg_s;
  assign cnt_inc_s = (starve_cnt_r == CNT_MAX) ? starve_cnt_r : (starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});

  // Next state, starvation count and buffer control
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = starve_cnt_r;
    load_s      = 1'b0;
    drop_s      = 1'b0;
    drain_s     = 1'b0;
    case (state_r)
      S_EMPTY: begin
        cnt_nxt_s = '0;
        if (lu_valid) begin
          load_s      = 1'b1;
          state_nxt_s = S_PEND;
        end else begin
          state_nxt_s = S_EMPTY;
        end
      end
      S_PEND, S_FORCE: begin
        if (grant_s == G_BUF) begin
          drain_s     = 1'b1;
          cnt_nxt_s   = '0;
          state_nxt_s = S_EMPTY;
        end else if ((grant_s == G_WB) && (wb_reg == buf_reg_s)) begin
          // younger WB result to the same register supersedes the buffered one
          drop_s      = 1'b1;
          cnt_nxt_s   = '0;
          state_nxt_s = S_EMPTY;
        end else if (grant_s == G_WB) begin
          cnt_nxt_s   = cnt_inc_s;
          state_nxt_s = (cnt_inc_s == CNT_MAX) ? S_FORCE : S_PEND;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        cnt_nxt_s   = '0;
        state_nxt_s = S_EMPTY;
      end
    endcase
  end

  // State and starvation counter registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r      <= S_EMPTY;
      starve_cnt_r <= '0;
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= cnt_nxt_s;
    end
  end

  // Granted request to write-port values; register 0 is consumed without a write
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = wb_reg;
    wr_data_s = wb_data;
    case (grant_s)
      G_WB: begin
        wr_en_s   = (wb_reg != '0);
        wr_addr_s = wb_reg;
        wr_data_s = wb_data;
      end
      G_BUF: begin
        wr_en_s   = (buf_reg_s != '0);
        wr_addr_s = buf_reg_s;
        wr_data_s = buf_data_s;
      end
      default: wr_en_s = 1'b0;
    endcase
  end

  // Write-port output registers; address/data hold unless a real write occurs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_en_s;
      if (wr_en_s) begin
        rf_waddr <= wr_addr_s;
        rf_wdata <= wr_data_s;
      end
    end
  end

`ifdef ARB_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stat_conflicts <= 16'd0;
      stat_forced    <= 16'd0;
    end else begin
      if (wb_valid && buf_valid_s) stat_conflicts <= sat16_inc(stat_conflicts);
      if (grant_s == G_BUF && state_r == S_FORCE) stat_forced <= sat16_inc(stat_forced);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed
// by random traffic, compared against a behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SM = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_reg = '0;
  logic [DW-1:0] wb_data = '0;
  logic          wb_stall;
  logic          lu_valid = 1'b0;
  logic [AW-1:0] lu_reg = '0;
  logic [DW-1:0] lu_data = '0;
  logic          lu_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          buf_busy;
  logic [AW-1:0] buf_reg;
`ifdef ARB_STATS_EN
  logic [15:0]   stat_conflicts;
  logic [15:0]   stat_forced;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  bit          m_full;
  int          m_wins;
  int          m_breg;
  int unsigned m_bdata;
  bit          m_we;
  int          m_addr;
  int unsigned m_data;
  bit          m_last_stall;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .wb_valid (wb_valid),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .wb_stall (wb_stall),
    .lu_valid (lu_valid),
    .lu_reg   (lu_reg),
    .lu_data  (lu_data),
    .lu_ready (lu_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
`ifdef ARB_STATS_EN
    .stat_conflicts (stat_conflicts),
    .stat_forced    (stat_forced),
`endif
    .buf_busy (buf_busy),
    .buf_reg  (buf_reg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0; m_wins = 0; m_breg = 0; m_bdata = 0;
    m_we = 1'b0; m_addr = 0; m_data = 0; m_last_stall = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},    {31'd0, rf_we},    32'd0);
    chk({tag, "_waddr"}, {27'd0, rf_waddr}, 32'd0);
    chk({tag, "_wdata"}, rf_wdata,          32'd0);
    chk({tag, "_stall"}, {31'd0, wb_stall}, 32'd0);
    chk({tag, "_ready"}, {31'd0, lu_ready}, 32'd1);
    chk({tag, "_busy"},  {31'd0, buf_busy}, 32'd0);
    chk({tag, "_breg"},  {27'd0, buf_reg},  32'd0);
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check write port
  task automatic cycle(input bit wv, input int wr, input int unsigned wd,
                       input bit lv, input int lr, input int unsigned ld);
    bit was_full;
    bit give_buf;
    bit give_wb;
    wb_valid = wv; wb_reg = AW'(wr); wb_data = wd;
    lu_valid = lv; lu_reg = AW'(lr); lu_data = ld;
    #1;
    was_full = m_full;
    give_buf = m_full && (m_wins >= SM || !wv);
    give_wb  = wv && !give_buf;
    m_last_stall = wv && !give_wb;
    chk("wb_stall", {31'd0, wb_stall}, {31'd0, m_last_stall});
    chk("lu_ready", {31'd0, lu_ready}, {31'd0, !m_full});
    chk("buf_busy", {31'd0, buf_busy}, {31'd0, m_full});
    chk("buf_reg",  {27'd0, buf_reg},  m_full ? m_breg : 0);
    m_we = 1'b0;
    if (give_wb) begin
      if (wr != 0) begin m_we = 1'b1; m_addr = wr; m_data = wd; end
      if (was_full) begin
        if (wr == m_breg) begin m_full = 1'b0; m_wins = 0; m_breg = 0; end
        else if (m_wins < SM) m_wins++;
      end
    end else if (give_buf) begin
      if (m_breg != 0) begin m_we = 1'b1; m_addr = m_breg; m_data = m_bdata; end
      m_full = 1'b0; m_wins = 0; m_breg = 0;
    end
    if (!was_full && lv) begin
      m_full = 1'b1; m_wins = 0; m_breg = lr; m_bdata = ld;
    end
    @(posedge clock); #1;
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("rf_waddr", {27'd0, rf_waddr}, m_addr);
    chk("rf_wdata", rf_wdata, m_data);
  endtask

  initial begin
    bit          cwv, clv;
    int          cwr, clr;
    int unsigned cwd, cld;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;

    // 1: plain WB write
    cycle(1'b1, 5, 32'hA5, 1'b0, 0, 0);
    chk("t1_addr", {27'd0, rf_waddr}, 32'd5);
    cycle(1'b0, 0, 0, 1'b0, 0, 0);
    // 2: LU result drains when WB idle
    cycle(1'b0, 0, 0, 1'b1, 7, 32'h77);
    cycle(1'b0, 0, 0, 1'b0, 0, 0);
    chk("t2_addr", {27'd0, rf_waddr}, 32'd7);
    cycle(1'b0, 0, 0, 1'b0, 0, 0);
    // 3: starvation forces the buffer through after SM WB wins
    cycle(1'b0, 0, 0, 1'b1, 7, 32'h7007);
    for (int i = 0; i < SM + 3; i++) cycle(1'b1, 10 + (i % 3), 32'h100 + i, 1'b0, 0, 0);
    // 4: same-destination drop
    cycle(1'b0, 0, 0, 1'b1, 9, 32'h9999);
    cycle(1'b1, 9, 32'h1234, 1'b0, 0, 0);
    chk("t4_data", rf_wdata, 32'h1234);
    cycle(1'b0, 0, 0, 1'b0, 0, 0);
    // 5: register 0 never written
    cycle(1'b1, 0, 32'hDEAD, 1'b1, 0, 32'hBEEF);
    cycle(1'b0, 0, 0, 1'b0, 0, 0);
    cycle(1'b0, 0, 0, 1'b0, 0, 0);
    // 6: reset while the buffer is in FORCE
    cycle(1'b0, 0, 0, 1'b1, 3, 32'h3333);
    for (int i = 0; i < SM; i++) cycle(1'b1, 4, 32'h44, 1'b0, 0, 0);
    wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h44;
    #3; resetn = 1'b0; #1;
    wb_valid = 1'b0; lu_valid = 1'b0;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
    cycle(1'b0, 0, 0, 1'b0, 0, 0);

    // random traffic; stalled WB and un-accepted LU hold their requests
    cwv = 1'b0; cwr = 0; cwd = 0; clv = 1'b0; clr = 0; cld = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(cwv && m_last_stall)) begin
        cwv = ($urandom_range(0, 99) < 60);
        cwr = $urandom_range(0, 7);
        cwd = $urandom;
      end
      if (!(clv && m_full)) begin
        clv = ($urandom_range(0, 99) < 40);
        clr = $urandom_range(0, 7);
        cld = $urandom;
      end
      cycle(cwv, cwr, cwd, clv, clr, cld);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
